// File: rtl/riscv_pkg.sv
// Shared RV32I branch constants and the B-type immediate decoder used by the
// fetch-side predictor.
package riscv_pkg;
  localparam logic [6:0] SB_TYPE_OP = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] BHT_INIT = 2'b01;

  function automatic logic [31:0] b_imm(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction
endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: one combinational read
// port, one registered update port, async reset to weakly not-taken.
module bht_2bit
  import riscv_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [1:0]          rd_ctr,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);
  localparam int DEPTH = 1 << IDX_BITS;

  logic [DEPTH-1:0][1:0] ctr_q, ctr_d;
  logic [1:0]            cur;

  // Read sees the pre-update value; no bypass from the write port.
  assign rd_ctr = ctr_q[rd_idx];
  assign cur    = ctr_q[wr_idx];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) begin
      if (wr_taken && cur != 2'b11)       ctr_d[wr_idx] = cur + 2'b01;
      else if (!wr_taken && cur != 2'b00) ctr_d[wr_idx] = cur - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctr_q <= {DEPTH{BHT_INIT}};
    else        ctr_q <= ctr_d;
  end
endmodule

// File: rtl/branch_predict_ctrl.sv
// Fetch-side branch predictor and EX-stage redirect controller with
// branch / mispredict performance counters.
module branch_predict_ctrl
  import riscv_pkg::*;
#(
  parameter int IDX_BITS = 4,
  parameter int PC_W     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  input  logic [31:0]     if_instr,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic [31:0]     br_cnt,
  output logic [31:0]     mispred_cnt
);
  logic [1:0]  rd_ctr;
  logic        is_sb;
  logic        res;
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // rst_n gates resolution so redirect/flushes stay low while reset is held.
  assign res      = rst_n & ex_valid & ex_is_branch & ~stall;
  assign redirect = res & (ex_taken != ex_pred_taken);
  assign flush_ifid = redirect;
  assign flush_idex = redirect;
  assign redirect_pc = ex_taken ? ex_target : ex_pc + PC_W'(4);

  assign is_sb       = (if_instr[6:0] == SB_TYPE_OP);
  assign pred_taken  = if_valid & is_sb & rd_ctr[1] & ~redirect;
  assign pred_target = if_pc + PC_W'($signed(b_imm(if_instr)));

  bht_2bit #(.IDX_BITS(IDX_BITS)) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (if_pc[IDX_BITS+1:2]),
    .rd_ctr   (rd_ctr),
    .wr_en    (res),
    .wr_idx   (ex_pc[IDX_BITS+1:2]),
    .wr_taken (ex_taken)
  );

  always_comb begin
    br_cnt_d      = br_cnt_q + {31'd0, res};
    mispred_cnt_d = mispred_cnt_q + {31'd0, redirect};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: prediction, resolution, training,
// stall hold, same-index read/write ordering and async reset.
module tb_branch_predict_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        stall;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush_ifid;
  logic        flush_idex;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] BEQ_P16 = 32'h0000_0863;  // beq imm=+16
  localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3;  // beq imm=-8
  localparam logic [31:0] ADDI    = 32'h0000_0013;

  branch_predict_ctrl #(.IDX_BITS(4), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .stall(stall), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic br, input logic [31:0] pc,
                        input logic tk, input logic [31:0] tgt, input logic pt);
    ex_valid = v; ex_is_branch = br; ex_pc = pc;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = pt;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0;
    if_valid = 1'b0; if_pc = '0; if_instr = '0;
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #12;
    rst_n = 1'b1;
    #1;

    // 1: reset state and first lookup
    if_valid = 1'b1; if_pc = 32'h40; if_instr = BEQ_P16;
    #1;
    chk("t1_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("t1_pred_target", pred_target, 32'h50);
    chk("t1_br_cnt", br_cnt, 32'd0);
    chk("t1_mispred_cnt", mispred_cnt, 32'd0);
    chk("t1_bht0", {30'd0, dut.u_bht.ctr_q[0]}, 32'h1);

    // negative immediate and modular wrap of the target adder
    if_instr = BEQ_M8;
    #1 chk("imm_neg_target", pred_target, 32'h38);
    if_pc = 32'h0;
    #1 chk("imm_wrap_target", pred_target, 32'hFFFF_FFF8);
    if_pc = 32'h40; if_instr = ADDI;
    #1 chk("non_sb_pred", {31'd0, pred_taken}, 32'd0);
    if_valid = 1'b0; if_instr = BEQ_P16;

    // 2: mispredicted taken branch
    tick();
    set_ex(1'b1, 1'b1, 32'h40, 1'b1, 32'h50, 1'b0);
    #1;
    chk("t2_redirect", {31'd0, redirect}, 32'd1);
    chk("t2_redirect_pc", redirect_pc, 32'h50);
    chk("t2_flush_ifid", {31'd0, flush_ifid}, 32'd1);
    chk("t2_flush_idex", {31'd0, flush_idex}, 32'd1);
    tick();
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    if_valid = 1'b1;
    #1;
    chk("t2_bht0", {30'd0, dut.u_bht.ctr_q[0]}, 32'h2);
    chk("t2_mispred_cnt", mispred_cnt, 32'd1);
    chk("t2_br_cnt", br_cnt, 32'd1);
    chk("t2_pred_after_train", {31'd0, pred_taken}, 32'd1);
    if_valid = 1'b0;

    // 3: three correctly predicted taken, then one not-taken
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 1'b1, 32'h40, 1'b1, 32'h50, 1'b1);
      #1 chk("t3_redirect_taken", {31'd0, redirect}, 32'd0);
      tick();
    end
    chk("t3_bht_sat", {30'd0, dut.u_bht.ctr_q[0]}, 32'h3);
    chk("t3_br_cnt", br_cnt, 32'd4);
    set_ex(1'b1, 1'b1, 32'h40, 1'b0, 32'h50, 1'b1);
    #1;
    chk("t3_nt_redirect", {31'd0, redirect}, 32'd1);
    chk("t3_nt_redirect_pc", redirect_pc, 32'h44);
    tick();
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("t3_bht_dec", {30'd0, dut.u_bht.ctr_q[0]}, 32'h2);
    chk("t3_mispred_cnt", mispred_cnt, 32'd2);

    // 4: stalled mispredicting branch resolves once on release
    stall = 1'b1;
    set_ex(1'b1, 1'b1, 32'h40, 1'b0, 32'h50, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_stall_redirect", {31'd0, redirect}, 32'd0);
      tick();
    end
    chk("t4_stall_br_cnt", br_cnt, 32'd5);
    chk("t4_stall_bht", {30'd0, dut.u_bht.ctr_q[0]}, 32'h2);
    stall = 1'b0;
    #1 chk("t4_release_redirect", {31'd0, redirect}, 32'd1);
    tick();
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("t4_br_cnt", br_cnt, 32'd6);
    chk("t4_mispred_cnt", mispred_cnt, 32'd3);
    chk("t4_bht", {30'd0, dut.u_bht.ctr_q[0]}, 32'h1);
    tick();
    chk("t4_no_second", br_cnt, 32'd6);

    // 5: same-index lookup and update in one cycle reads the old value
    if_valid = 1'b1; if_pc = 32'h80; if_instr = BEQ_P16;
    set_ex(1'b1, 1'b1, 32'h40, 1'b1, 32'h50, 1'b1);
    #1 chk("t5_old_value", {31'd0, pred_taken}, 32'd0);
    tick();
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1 chk("t5_new_value", {31'd0, pred_taken}, 32'd1);

    // redirect in the same cycle forces pred_taken low
    set_ex(1'b1, 1'b1, 32'h44, 1'b1, 32'h60, 1'b0);
    #1 chk("redir_kills_pred", {31'd0, pred_taken}, 32'd0);
    tick();
    chk("redir_br_cnt", br_cnt, 32'd8);
    chk("redir_mispred_cnt", mispred_cnt, 32'd4);
    chk("redir_bht1", {30'd0, dut.u_bht.ctr_q[1]}, 32'h2);

    // non-branch in EX is ignored
    set_ex(1'b1, 1'b0, 32'h48, 1'b0, 32'h0, 1'b1);
    #1 chk("nonbr_redirect", {31'd0, redirect}, 32'd0);
    tick();
    chk("nonbr_br_cnt", br_cnt, 32'd8);
    chk("nonbr_mispred_cnt", mispred_cnt, 32'd4);

    // 6: async reset mid-cycle with a mispredicting branch in EX
    set_ex(1'b1, 1'b1, 32'h40, 1'b1, 32'h50, 1'b0);
    if_pc = 32'h40;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_br_cnt", br_cnt, 32'd0);
    chk("t6_mispred_cnt", mispred_cnt, 32'd0);
    chk("t6_bht0", {30'd0, dut.u_bht.ctr_q[0]}, 32'h1);
    chk("t6_bht1", {30'd0, dut.u_bht.ctr_q[1]}, 32'h1);
    chk("t6_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("t6_redirect", {31'd0, redirect}, 32'd0);
    chk("t6_flush", {30'd0, flush_ifid, flush_idex}, 32'd0);
    tick();
    rst_n = 1'b1;
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
